// File: rtl/sd_pkg.sv
// Shared constants, state/op encodings and the byte-lane merge helper for the
// single-sector SD write-back buffer.
package sd_pkg;

  localparam int unsigned SectorBits     = 4096;
  localparam int unsigned WordBits       = 32;
  localparam int unsigned WordsPerSector = SectorBits / WordBits;
  localparam int unsigned ByteLanes      = WordBits / 8;

  // SectorIdx = addr[31:9], WordIdx = addr[8:2]
  localparam int unsigned SectorIdxMsb = 31;
  localparam int unsigned SectorIdxLsb = 9;
  localparam int unsigned WordIdxMsb   = 8;
  localparam int unsigned WordIdxLsb   = 2;
  localparam int unsigned TagBits      = SectorIdxMsb - SectorIdxLsb + 1;
  localparam int unsigned WordIdxBits  = WordIdxMsb - WordIdxLsb + 1;

  typedef enum logic [1:0] {
    Idle,
    WriteBack,
    Fill,
    Done
  } state_t;

  typedef enum logic [1:0] {
    OpRead,
    OpWrite,
    OpFlush
  } op_t;

  function automatic logic [WordBits-1:0] merge_bytes(
    input logic [WordBits-1:0]  old_word,
    input logic [WordBits-1:0]  new_word,
    input logic [ByteLanes-1:0] byte_en
  );
    logic [WordBits-1:0] result;
    result = old_word;
    for (int unsigned b = 0; b < ByteLanes; b++) begin
      if (byte_en[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/sd_sector_buffer_if.sv
// CPU-side word bus of the sector buffer: request held until a one-cycle ack.
interface sd_sector_buffer_if;
  import sd_pkg::*;

  logic                 rd_en;
  logic                 wr_en;
  logic                 flush;
  logic [31:0]          addr;
  logic [WordBits-1:0]  write_data;
  logic [ByteLanes-1:0] byte_en;
  logic [WordBits-1:0]  read_data;
  logic                 ack;
  logic                 busy;

  modport master (
    output rd_en, wr_en, flush, addr, write_data, byte_en,
    input  read_data, ack, busy
  );

  modport slave (
    input  rd_en, wr_en, flush, addr, write_data, byte_en,
    output read_data, ack, busy
  );

endinterface

// File: rtl/sd_sector_buffer.sv
// Single-sector write-back cache between the 32-bit CPU bus and the block-level
// sd_controller2 interface; misses write back a dirty sector before refilling.
module sd_sector_buffer
  import sd_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  sd_sector_buffer_if.slave     bus,
  output logic                  sd_rd_en,
  output logic                  sd_wr_en,
  output logic [31:0]           sd_addr,
  output logic [SectorBits-1:0] sd_write_data,
  input  logic [SectorBits-1:0] sd_read_data,
  input  logic                  sd_busy
);

  logic [SectorBits-1:0] buffer;
  logic [TagBits-1:0]    tag;
  logic                  valid;
  logic                  dirty;
  logic                  busy_seen;
  state_t                state;
  op_t                   op;
  logic [WordBits-1:0]   read_data_q;
  logic                  ack_q;
  logic                  busy_q;

  logic [TagBits-1:0]     req_tag;
  logic [WordIdxBits-1:0] req_word;
  logic                   request;
  logic                   hit;
  op_t                    req_op;
  logic [WordBits-1:0]    cur_word;
  logic [WordBits-1:0]    merged_word;
  logic                   unused_addr_lsbs;

  assign req_tag          = bus.addr[SectorIdxMsb:SectorIdxLsb];
  assign req_word         = bus.addr[WordIdxMsb:WordIdxLsb];
  assign unused_addr_lsbs = ^bus.addr[WordIdxLsb-1:0];
  assign request          = bus.flush | bus.rd_en | bus.wr_en;
  assign hit              = valid && (tag == req_tag);
  assign cur_word         = buffer[req_word * WordBits +: WordBits];
  assign merged_word      = merge_bytes(cur_word, bus.write_data, bus.byte_en);

  always_comb begin
    req_op = OpWrite;
    if (bus.flush)      req_op = OpFlush;
    else if (bus.rd_en) req_op = OpRead;
  end

  assign bus.read_data = read_data_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign sd_write_data = buffer;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= Idle;
      op          <= OpRead;
      valid       <= 1'b0;
      dirty       <= 1'b0;
      tag         <= '0;
      busy_seen   <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      sd_rd_en    <= 1'b0;
      sd_wr_en    <= 1'b0;
      sd_addr     <= '0;
      read_data_q <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        Idle: begin
          // ack_q high means the bus has not yet released the finished request
          if (request && !ack_q) begin
            op <= req_op;
            if ((req_op == OpFlush && valid && dirty) ||
                (req_op != OpFlush && !hit && valid && dirty)) begin
              state     <= WriteBack;
              sd_wr_en  <= 1'b1;
              sd_addr   <= {{(32-TagBits){1'b0}}, tag};
              busy_seen <= 1'b0;
              busy_q    <= 1'b1;
            end else if (req_op != OpFlush && !hit) begin
              state     <= Fill;
              sd_rd_en  <= 1'b1;
              sd_addr   <= {{(32-TagBits){1'b0}}, req_tag};
              busy_seen <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              ack_q <= 1'b1;
              if (req_op == OpRead) begin
                read_data_q <= cur_word;
              end else if (req_op == OpWrite) begin
                buffer[req_word * WordBits +: WordBits] <= merged_word;
                dirty <= 1'b1;
              end
            end
          end
        end

        WriteBack: begin
          if (sd_busy) busy_seen <= 1'b1;
          if (busy_seen && !sd_busy) begin
            sd_wr_en  <= 1'b0;
            dirty     <= 1'b0;
            busy_seen <= 1'b0;
            if (op == OpFlush) begin
              state <= Done;
            end else begin
              state    <= Fill;
              sd_rd_en <= 1'b1;
              sd_addr  <= {{(32-TagBits){1'b0}}, req_tag};
            end
          end
        end

        Fill: begin
          if (sd_busy) busy_seen <= 1'b1;
          if (busy_seen && !sd_busy) begin
            buffer    <= sd_read_data;
            tag       <= req_tag;
            valid     <= 1'b1;
            sd_rd_en  <= 1'b0;
            busy_seen <= 1'b0;
            state     <= Done;
          end
        end

        Done: begin
          if (op == OpRead) begin
            read_data_q <= cur_word;
          end else if (op == OpWrite) begin
            buffer[req_word * WordBits +: WordBits] <= merged_word;
            dirty <= 1'b1;
          end
          ack_q  <= 1'b1;
          busy_q <= 1'b0;
          state  <= Idle;
        end

        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Directed bench for sd_sector_buffer with a cycle-level model of the SD
// controller's busy handshake.
module tb_sd_sector_buffer;
  import sd_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  sd_rd_en, sd_wr_en, sd_busy;
  logic [31:0]           sd_addr;
  logic [SectorBits-1:0] sd_write_data, sd_read_data;

  sd_sector_buffer_if bus ();

  sd_sector_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .sd_rd_en     (sd_rd_en),
    .sd_wr_en     (sd_wr_en),
    .sd_addr      (sd_addr),
    .sd_write_data(sd_write_data),
    .sd_read_data (sd_read_data),
    .sd_busy      (sd_busy)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // controller model bookkeeping
  int                    rd_count = 0, wr_count = 0, ev_seq = 0, rd_seq = 0, wr_seq = 0;
  int                    both_high = 0;
  logic [31:0]           rd_addr, wr_addr;
  logic [SectorBits-1:0] wr_image;

  function automatic logic [SectorBits-1:0] sector_image(input logic [22:0] s);
    logic [SectorBits-1:0] img;
    for (int k = 0; k < 128; k++) img[32*k +: 32] = {16'hC0DE, s[7:0], 8'(k)};
    return img;
  endfunction

  initial begin
    int   phase;
    int   cnt;
    logic last_wr;
    phase = 0; cnt = 0; last_wr = 1'b0;
    sd_busy = 1'b0;
    sd_read_data = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        phase = 0; sd_busy = 1'b0;
      end else begin
        case (phase)
          0: if (sd_wr_en || sd_rd_en) begin
            ev_seq++;
            if (sd_wr_en) begin
              wr_count++; wr_seq = ev_seq; wr_addr = sd_addr; wr_image = sd_write_data;
              last_wr = 1'b1;
            end else begin
              rd_count++; rd_seq = ev_seq; rd_addr = sd_addr;
              sd_read_data = sector_image(sd_addr[22:0]);
              last_wr = 1'b0;
            end
            phase = 1;
          end
          1: begin sd_busy = 1'b1; cnt = 1; phase = 2; end
          2: begin
            cnt++;
            if (cnt == 3) begin sd_busy = 1'b0; phase = 3; end
          end
          default: if (last_wr ? !sd_wr_en : !sd_rd_en) phase = 0;
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (sd_rd_en && sd_wr_en) both_high++;
  end

  task automatic bus_op(input logic r, input logic w, input logic f, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output int lat, output logic busy_any);
    logic ok;
    @(posedge clock); #1;
    bus.rd_en = r; bus.wr_en = w; bus.flush = f;
    bus.addr = a; bus.write_data = d; bus.byte_en = be;
    ok = 1'b0; lat = 0; busy_any = 1'b0; rd = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clock); #1;
      lat++;
      if (bus.ack) begin
        ok = 1'b1; rd = bus.read_data;
      end else if (bus.busy) begin
        busy_any = 1'b1;
      end
    end
    total++;
    if (!ok) $display("FAIL ack_timeout addr=%h got no ack, required ack within 200 cycles", a);
    else passed++;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.flush = 1'b0;
    bus.addr = '0; bus.write_data = '0; bus.byte_en = '0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({bus.ack, bus.busy, sd_rd_en, sd_wr_en} !== 4'b0000)
      $display("FAIL reset_ctrl got %b required 0000", {bus.ack, bus.busy, sd_rd_en, sd_wr_en});
    else passed++;
    total++;
    if (bus.read_data !== 32'h0 || sd_addr !== 32'h0)
      $display("FAIL reset_data got rd=%h sd_addr=%h required 0/0", bus.read_data, sd_addr);
    else passed++;
    total++;
    if ({dut.valid, dut.dirty} !== 2'b00)
      $display("FAIL reset_flags got %b required 00", {dut.valid, dut.dirty});
    else passed++;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_read_miss();
    logic [31:0] rd; int lat; logic busy_any; int r0, w0;
    r0 = rd_count; w0 = wr_count;
    bus_op(1, 0, 0, 32'h0000_0204, '0, '0, rd, lat, busy_any);
    total++;
    if (rd !== 32'hC0DE_0101) $display("FAIL miss_data got %h required C0DE0101", rd);
    else passed++;
    total++;
    if (rd_count - r0 !== 1 || rd_addr !== 32'h1 || wr_count !== w0)
      $display("FAIL miss_traffic got rd=%0d addr=%h wr=%0d required 1/1/0", rd_count - r0, rd_addr, wr_count - w0);
    else passed++;
    total++;
    if (!busy_any || lat <= 1 || bus.busy !== 1'b0)
      $display("FAIL miss_busy got busy_any=%b lat=%0d busy_at_ack=%b required 1/>1/0", busy_any, lat, bus.busy);
    else passed++;
  endtask

  task automatic test_read_hit();
    logic [31:0] rd; int lat; logic busy_any; int r0, w0;
    r0 = rd_count; w0 = wr_count;
    bus_op(1, 0, 0, 32'h0000_0208, '0, '0, rd, lat, busy_any);
    total++;
    if (rd !== 32'hC0DE_0102 || lat !== 1)
      $display("FAIL hit_read got %h lat=%0d required C0DE0102 lat=1", rd, lat);
    else passed++;
    total++;
    if (busy_any || bus.busy !== 1'b0 || rd_count !== r0 || wr_count !== w0)
      $display("FAIL hit_quiet got busy=%b sd_ops=%0d required 0/0", busy_any, rd_count - r0 + wr_count - w0);
    else passed++;
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int lat; logic busy_any;
    bus_op(0, 1, 0, 32'h0000_0204, 32'hDEAD_BEEF, 4'b0101, rd, lat, busy_any);
    total++;
    if (lat !== 1 || dut.dirty !== 1'b1)
      $display("FAIL write_hit got lat=%0d dirty=%b required 1/1", lat, dut.dirty);
    else passed++;
    bus_op(1, 0, 0, 32'h0000_0204, '0, '0, rd, lat, busy_any);
    total++;
    if (rd !== 32'hC0AD_01EF) $display("FAIL write_merge got %h required C0AD01EF", rd);
    else passed++;
  endtask

  task automatic test_back_to_back_writeback();
    logic [31:0] rd; int lat; logic busy_any; int r0, w0;
    r0 = rd_count; w0 = wr_count;
    bus_op(1, 0, 0, 32'h0000_0400, '0, '0, rd, lat, busy_any);
    total++;
    if (rd !== 32'hC0DE_0200) $display("FAIL evict_data got %h required C0DE0200", rd);
    else passed++;
    total++;
    if (wr_count - w0 !== 1 || wr_addr !== 32'h1 ||
        wr_image[63:32] !== 32'hC0AD_01EF || wr_image[31:0] !== 32'hC0DE_0100)
      $display("FAIL evict_wb got n=%0d addr=%h w1=%h w0=%h required 1/1/C0AD01EF/C0DE0100",
               wr_count - w0, wr_addr, wr_image[63:32], wr_image[31:0]);
    else passed++;
    total++;
    if (rd_count - r0 !== 1 || rd_addr !== 32'h2 || wr_seq >= rd_seq || dut.dirty !== 1'b0)
      $display("FAIL evict_fill got n=%0d addr=%h order=%0d/%0d dirty=%b required 1/2/wr<rd/0",
               rd_count - r0, rd_addr, wr_seq, rd_seq, dut.dirty);
    else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] rd; int lat; logic busy_any; int r0, w0;
    r0 = rd_count; w0 = wr_count;
    bus_op(0, 0, 1, 32'h0, '0, '0, rd, lat, busy_any);
    total++;
    if (lat !== 1 || rd_count !== r0 || wr_count !== w0)
      $display("FAIL flush_clean got lat=%0d sd_ops=%0d required 1/0", lat, rd_count - r0 + wr_count - w0);
    else passed++;
    bus_op(0, 1, 0, 32'h0000_0404, 32'h1234_5678, 4'b1111, rd, lat, busy_any);
    // flush also asserted with rd_en: flush wins
    bus_op(1, 0, 1, 32'h0000_0800, '0, '0, rd, lat, busy_any);
    total++;
    if (wr_count - w0 !== 1 || wr_addr !== 32'h2 || wr_image[63:32] !== 32'h1234_5678 || rd_count !== r0)
      $display("FAIL flush_dirty got wr=%0d addr=%h w1=%h rd=%0d required 1/2/12345678/0",
               wr_count - w0, wr_addr, wr_image[63:32], rd_count - r0);
    else passed++;
    total++;
    if ({dut.valid, dut.dirty} !== 2'b10 || lat <= 1)
      $display("FAIL flush_state got valid/dirty=%b lat=%0d required 10/>1", {dut.valid, dut.dirty}, lat);
    else passed++;
    bus_op(1, 0, 0, 32'h0000_0404, '0, '0, rd, lat, busy_any);
    total++;
    if (rd !== 32'h1234_5678 || lat !== 1)
      $display("FAIL flush_keep got %h lat=%0d required 12345678 lat=1", rd, lat);
    else passed++;
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd; int lat; logic busy_any; int r0; logic seen;
    r0 = rd_count;
    @(posedge clock); #1;
    bus.rd_en = 1'b1; bus.addr = 32'h0000_0800;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clock); #1;
      if (sd_rd_en) seen = 1'b1;
    end
    total++;
    if (!seen) $display("FAIL midfill_start got no sd_rd_en required sd_rd_en within 50 cycles");
    else passed++;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if ({sd_rd_en, bus.busy, dut.valid, bus.ack} !== 4'b0000)
      $display("FAIL midfill_reset got %b required 0000", {sd_rd_en, bus.busy, dut.valid, bus.ack});
    else passed++;
    bus.rd_en = 1'b0;
    @(negedge clock); reset = 1'b0;
    bus_op(1, 0, 0, 32'h0000_0800, '0, '0, rd, lat, busy_any);
    total++;
    if (rd !== 32'hC0DE_0400 || rd_count - r0 !== 2 || rd_addr !== 32'h4)
      $display("FAIL midfill_refill got %h fills=%0d addr=%h required C0DE0400/2/4", rd, rd_count - r0, rd_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_back_to_back_writeback();
    test_flush();
    test_reset_mid_fill();
    total++;
    if (both_high !== 0) $display("FAIL en_exclusive got %0d cycles both high required 0", both_high);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sd_sector_buffer.md
Name: sd_sector_buffer

Overview:
Single-sector write-back buffer between the CPU data bus and sd_controller2. It turns 32-bit word reads and writes into whole-sector (4096-bit) block reads and writes on the controller's rd_en/wr_en/addr/read_data/write_data/busy interface. Hits are served from the buffer. A miss writes back the dirty sector, if any, then fills the new one. An explicit flush forces write-back.

Parameters:
SectorBits, 4096, sector size in bits; must match sd_controller2.
WordBits, 32, bus word width; SectorBits/WordBits words per sector (128).

Ports:
clock  in  1  system clock; same domain as sd_controller2 clock_50M.
reset  in  1  synchronous, active-high reset.
rd_en  in  1  bus word read request.
wr_en  in  1  bus word write request.
flush  in  1  write back the buffer if dirty.
addr  in  32  byte address; addr[31:9] sector, addr[8:2] word, addr[1:0] ignored.
write_data  in  32  bus write word.
byte_en  in  4  byte lanes written on wr_en.
read_data  out  32  word returned on read ack.
ack  out  1  one-cycle completion pulse.
busy  out  1  high from acceptance of a missing/flush request until its ack.
sd_rd_en  out  1  block read request to the controller.
sd_wr_en  out  1  block write request to the controller.
sd_addr  out  32  block index, {9'b0, sector}.
sd_write_data  out  4096  sector image for write-back.
sd_read_data  in  4096  sector from the controller.
sd_busy  in  1  controller busy.

Behaviour:
- Reset: valid=0, dirty=0, tag=0, state=Idle; ack, busy, sd_rd_en, sd_wr_en=0; read_data=0, sd_addr=0. Buffer contents are don't-care.
- Requests: bus holds rd_en/wr_en/flush/addr/data stable until ack. Requests are accepted only in Idle.
- Priority when several are asserted: flush > rd_en > wr_en.
- Hit: valid && tag==addr[31:9]. Accepted at edge N; ack=1 at N+1.
  - A read hit drives read_data at N+1.
  - A write hit merges byte_en lanes into word addr[8:2] and sets dirty.
  - busy stays 0 on a hit.
- Miss: busy=1 from N+1.
  - If dirty, go to WriteBack, else go to Fill.
- WriteBack:
  - sd_wr_en=1, sd_addr=tag, sd_write_data=buffer.
  - Held until sd_busy is seen high and then low; a sticky busy_seen flag records the rise.
  - Then sd_wr_en=0, dirty=0, and the block goes to Fill, or to Done for a flush.
- Fill:
  - sd_rd_en=1, sd_addr=addr[31:9].
  - On the cycle busy_seen && !sd_busy: capture sd_read_data into the buffer, tag=addr[31:9], valid=1, sd_rd_en=0, then go to Done.
- Done: performs the pending word access exactly as a hit, pulses ack, clears busy, and returns to Idle.
- States: Idle, WriteBack, Fill, Done.
- sd_rd_en and sd_wr_en are never both high; each deasserts in the cycle after busy falls.
- Flush:
  - When clean or invalid: ack at N+1, no SD traffic.
  - When dirty: WriteBack, then ack. Buffer stays valid and becomes clean.
- Word layout: word k is buffer[32k+:32]; byte b of a word is bits [8b+:8].
- The same sector re-requested after a fill is a hit with no SD traffic.
- Reset mid-operation: everything returns to reset values on the next edge and dirty data is lost. The sd_*_en outputs drop on the next edge, and the controller is reset by the same reset.
- No timeout: a hung sd_busy keeps busy=1 indefinitely.

Decomposition:
- Package sd_pkg holds:
  - SectorBits, WordBits, SectorIdx=addr[31:9], WordIdx=addr[8:2];
  - the state encoding {Idle, WriteBack, Fill, Done};
  - the byte-merge function (old word, new word, byte_en).
- Sub-module: none. The 4096-bit buffer is an internal register array and the merge logic is the package function.

Test Plan:
1. Reset, then read addr 0x00000204. Expect sd_rd_en=1 with sd_addr=0x1 until sd_busy falls, then ack with read_data=model word 1 of sector 1. Expect no sd_wr_en.
2. After (1), read 0x00000208. Expect ack one cycle later, busy=0, no SD traffic.
3. Write 0xDEADBEEF to 0x00000204 with byte_en=4'b0101, then read it back. Expect bytes 0 and 2 from 0xDEADBEEF and bytes 1 and 3 from the original, with dirty=1.
4. Read 0x00000400 (sector 2) while dirty. Expect sd_wr_en with sd_addr=0x1 and the modified image in the model first, then sd_rd_en with sd_addr=0x2, then ack.
5. Flush while clean: ack next cycle, no SD traffic. Flush while dirty: one write-back, then ack with dirty=0.
6. Assert reset during Fill. Next cycle: sd_rd_en=0, busy=0, valid=0. A subsequent read of the same address misses and refills.
